// File: rtl/fnd_display_arbiter.sv
// Round-robin APB master sharing one FND display among N_REQ requesters.
// Optional PREADY watchdog enabled by defining FND_ARB_TIMEOUT_EN.
module fnd_display_arbiter #(
  parameter int N_REQ          = 4,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*14-1:0] req_num,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic                err,
  output logic [2:0]          PADDR,
  output logic                PWRITE,
  output logic                PSEL,
  output logic                PENABLE,
  output logic [31:0]         PWDATA,
  input  logic                PREADY
);

  localparam int PW   = $clog2(N_REQ);
  localparam int CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ?
                        HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [13:0]   NUM_MAX   = 14'd9999;

  typedef enum logic [2:0] {
    IDLE,
    SET_D,
    ACC_D,
    SET_E,
    ACC_E,
    HOLD,
    SET_OFF,
    ACC_OFF
  } st_t;

  st_t           st;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          disp_on;

  logic [13:0]      req_nums [N_REQ];
  logic             win_vld;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic [N_REQ-1:0] win_oh;
  logic [13:0]      win_raw;
  logic [13:0]      win_num;
  logic             in_acc;
  logic             acc_to;

  for (genvar g = 0; g < N_REQ; g++) begin : g_num
    assign req_nums[g] = req_num[14*g +: 14];
  end

  // Search from ptr+1 around the ring; nearest requester wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  assign win_oh  = N_REQ'(1) << win;
  assign win_raw = req_nums[win];
  assign win_num = (win_raw > NUM_MAX) ? NUM_MAX : win_raw;
  assign PWRITE  = PSEL;

  assign in_acc = (st == ACC_D) || (st == ACC_E) ||
                  (st == ACC_OFF);

`ifdef FND_ARB_TIMEOUT_EN
  assign acc_to = !PREADY &&
                  (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign acc_to = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      st      <= IDLE;
      ptr     <= PW'(N_REQ - 1);
      cnt     <= '0;
      disp_on <= 1'b0;
      grant   <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      PADDR   <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWDATA  <= '0;
    end else begin
      err <= 1'b0;
      if (in_acc && acc_to) begin
        st      <= IDLE;
        busy    <= 1'b0;
        err     <= 1'b1;
        grant   <= '0;
        disp_on <= 1'b0;
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
        cnt     <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            if (win_vld) begin
              st     <= SET_D;
              busy   <= 1'b1;
              grant  <= win_oh;
              ptr    <= win;
              PSEL   <= 1'b1;
              PADDR  <= 3'h4;
              PWDATA <= {18'd0, win_num};
            end
          end
          SET_D: begin
            st      <= ACC_D;
            PENABLE <= 1'b1;
            cnt     <= '0;
          end
          SET_E: begin
            st      <= ACC_E;
            PENABLE <= 1'b1;
            cnt     <= '0;
          end
          SET_OFF: begin
            st      <= ACC_OFF;
            PENABLE <= 1'b1;
            cnt     <= '0;
          end
          ACC_D: begin
            if (PREADY) begin
              PENABLE <= 1'b0;
              cnt     <= '0;
              if (disp_on) begin
                st   <= HOLD;
                PSEL <= 1'b0;
              end else begin
                st     <= SET_E;
                PADDR  <= 3'h0;
                PWDATA <= 32'h1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACC_E: begin
            if (PREADY) begin
              st      <= HOLD;
              disp_on <= 1'b1;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (!req[ptr] || cnt == HOLD_LAST) begin
              cnt <= '0;
              // Re-arbitrate on the exit edge, no idle gap.
              if (win_vld) begin
                st     <= SET_D;
                grant  <= win_oh;
                ptr    <= win;
                PSEL   <= 1'b1;
                PADDR  <= 3'h4;
                PWDATA <= {18'd0, win_num};
              end else begin
                grant <= '0;
                if (disp_on) begin
                  st     <= SET_OFF;
                  PSEL   <= 1'b1;
                  PADDR  <= 3'h0;
                  PWDATA <= 32'h0;
                end else begin
                  st   <= IDLE;
                  busy <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACC_OFF: begin
            if (PREADY) begin
              st      <= IDLE;
              busy    <= 1'b0;
              disp_on <= 1'b0;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
